// File: rtl/cpu_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the FSM state encoding, the owner tag and the timeout fill pattern.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  // Width of the fairness counter; FAIR_LIMIT is bounded to 1..15.
  localparam int FAIR_CW = 4;

endpackage

// File: rtl/mem_arb_fair_cnt.sv
// Winner select for the IF/DM arbiter with a saturating counter of IF losses.
// DM normally wins a tie; after FAIR_LIMIT straight losses IF is forced through.
module mem_arb_fair_cnt
  import cpu_mem_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic if_wins_o
);

  localparam logic [FAIR_CW-1:0] LIMIT   = FAIR_CW'(FAIR_LIMIT);
  localparam logic [FAIR_CW-1:0] CNT_MAX = '1;

  logic [FAIR_CW-1:0] fair_cnt;

  assign if_wins_o = if_req_i & (~dm_req_i | (fair_cnt == LIMIT));

  // A dropped IF request forgets its history, so stale losses never carry over.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fair_cnt <= '0;
    end else if (!if_req_i) begin
      fair_cnt <= '0;
    end else if (arb_i) begin
      if (if_wins_o) begin
        fair_cnt <= '0;
      end else if (fair_cnt != CNT_MAX) begin
        fair_cnt <= fair_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and DM pipeline stages.
// One transaction at a time over a req/ack handshake, with per-port ready pulses.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// ISSUE | mem_req_o high, waiting for mem_ack_i or the wait timer to expire
// RESP  | owner's ready pulse is high; requests are not sampled
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_o,
  output logic          err_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [DW-1:0] TO_DATA   = DW'(TIMEOUT_DATA);

  state_e        state;
  owner_e        owner;
  logic [TW-1:0] wait_cnt;
  logic          arb_go;
  logic          if_wins;
  logic          timeout_hit;

  assign arb_go      = (state == IDLE) & (if_req_i | dm_req_i);
  // Down-counter reaching zero means this is the TIMEOUT-th ISSUE cycle without ack.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == '0);

  assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

  mem_arb_fair_cnt #(
    .FAIR_LIMIT (FAIR_LIMIT)
  ) u_fair_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arb_i     (arb_go),
    .if_req_i  (if_req_i),
    .dm_req_i  (dm_req_i),
    .if_wins_o (if_wins)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      wait_cnt    <= '0;
      if_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ready_o  <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_go) begin
            owner       <= if_wins ? OWN_IF : OWN_DM;
            mem_req_o   <= 1'b1;
            mem_we_o    <= if_wins ? 1'b0 : dm_we_i;
            mem_addr_o  <= if_wins ? if_addr_i : dm_addr_i;
            mem_wdata_o <= if_wins ? '0 : dm_wdata_i;
            wait_cnt    <= WAIT_LOAD;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // Ack takes priority over an expiring timer in the same cycle.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= RESP;
            if (owner == OWN_IF) begin
              if_rdata_o <= mem_rdata_i;
              if_ready_o <= 1'b1;
            end else begin
              dm_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
              dm_ready_o <= 1'b1;
            end
          end else if (timeout_hit) begin
            err_o     <= 1'b1;
            mem_req_o <= 1'b0;
            state     <= RESP;
            if (owner == OWN_IF) begin
              if_rdata_o <= TO_DATA;
              if_ready_o <= 1'b1;
            end else begin
              dm_rdata_o <= TO_DATA;
              dm_ready_o <= 1'b1;
            end
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a simple memory model,
// and a monitor that checks every ready pulse and every memory request against expectations.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  req_t        if_q[$];
  req_t        dm_q[$];
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  req_t        mem_exp[$];

  bit ack_en    = 1'b1;
  int ack_delay = 0;
  bit force_ack = 1'b0;
  bit ack_extra = 1'b0;
  int wait_n    = 0;
  bit ack_hold  = 1'b0;
  bit mem_req_prev = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .AW(32), .DW(32), .FAIR_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ready_o  (if_ready_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ready_o  (dm_ready_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h40:  mem_val = 32'h0000_1234;
      32'h44:  mem_val = 32'h0000_4444;
      32'h80:  mem_val = 32'h0000_7777;
      32'h200: mem_val = 32'hCAFE_0200;
      default: mem_val = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Requesters: present the head of each queue, retire it on its ready pulse.
  always @(negedge clk_i) begin
    if (if_ready_o && if_q.size() > 0) void'(if_q.pop_front());
    if (dm_ready_o && dm_q.size() > 0) void'(dm_q.pop_front());
    if (if_q.size() > 0) begin
      if_req_i  = 1'b1;
      if_addr_i = if_q[0].addr;
    end else begin
      if_req_i = 1'b0;
    end
    if (dm_q.size() > 0) begin
      dm_req_i   = 1'b1;
      dm_we_i    = dm_q[0].we;
      dm_addr_i  = dm_q[0].addr;
      dm_wdata_i = dm_q[0].wdata;
    end else begin
      dm_req_i = 1'b0;
    end
  end

  // Memory model: ack ack_delay cycles into the request, optionally one stray ack after.
  always @(negedge clk_i) begin
    if (force_ack) begin
      mem_ack_i = 1'b1;
    end else if (mem_req_o && ack_en) begin
      if (wait_n == ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_val(mem_addr_o);
        wait_n      = 0;
        ack_hold    = ack_extra;
      end else begin
        mem_ack_i = 1'b0;
        wait_n++;
      end
    end else if (ack_hold) begin
      mem_ack_i = 1'b1;
      ack_hold  = 1'b0;
      wait_n    = 0;
    end else begin
      mem_ack_i = 1'b0;
      wait_n    = 0;
    end
  end

  // Monitor: compares each ready pulse and each new memory request with the queues.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (if_ready_o || dm_ready_o)
        check("ready_exclusive", 80'(if_ready_o & dm_ready_o), 80'd0);
      if (if_ready_o) begin
        if (if_exp.size() == 0) check("if_unexpected_ready", 80'(if_ready_o), 80'd0);
        else check("if_rdata", 80'(if_rdata_o), 80'(if_exp.pop_front()));
      end
      if (dm_ready_o) begin
        if (dm_exp.size() == 0) check("dm_unexpected_ready", 80'(dm_ready_o), 80'd0);
        else check("dm_rdata", 80'(dm_rdata_o), 80'(dm_exp.pop_front()));
      end
      if (mem_req_o && !mem_req_prev) begin
        if (mem_exp.size() == 0) begin
          check("mem_unexpected_req", 80'(mem_req_o), 80'd0);
        end else begin
          req_t e;
          e = mem_exp.pop_front();
          check("mem_we",    80'(mem_we_o),    80'(e.we));
          check("mem_addr",  80'(mem_addr_o),  80'(e.addr));
          check("mem_wdata", 80'(mem_wdata_o), 80'(e.wdata));
        end
      end
    end
    mem_req_prev = mem_req_o;
  end

  task automatic push_if(input logic [31:0] addr, input logic [31:0] exp_data);
    req_t r;
    r = '{we: 1'b0, addr: addr, wdata: 32'h0};
    if_q.push_back(r);
    if_exp.push_back(exp_data);
  endtask

  task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data);
    req_t r;
    r = '{we: we, addr: addr, wdata: wdata};
    dm_q.push_back(r);
    dm_exp.push_back(exp_data);
  endtask

  task automatic expect_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r = '{we: we, addr: addr, wdata: wdata};
    mem_exp.push_back(r);
  endtask

  task automatic wait_ready(input bit dm, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(dm ? dm_ready_o : if_ready_o) && n < 40);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i);
      #1;
      if (if_q.size() == 0 && dm_q.size() == 0 && !mem_req_o && !if_ready_o && !dm_ready_o)
        break;
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mem_req", 80'(mem_req_o), 80'd0);
    check("rst_ready", 80'({if_ready_o, dm_ready_o}), 80'd0);
    check("rst_rdata", 80'({if_rdata_o, dm_rdata_o}), 80'd0);
    check("rst_mem_bus", 80'({mem_we_o, mem_addr_o, mem_wdata_o}), 80'd0);
    check("rst_err", 80'(err_o), 80'd0);
    check("rst_stall", 80'(stall_o), 80'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // IF-only read, minimum latency
    push_if(32'h40, 32'h1234);
    expect_mem(1'b0, 32'h40, 32'h0);
    @(negedge clk_i);
    #1;
    check("stall_pending", 80'(stall_o), 80'd1);
    wait_ready(1'b0, n);
    check("if_min_latency", 80'(n + 1), 80'd3);
    #1;
    check("stall_after_ready", 80'(stall_o), 80'd0);
    wait_quiet();

    // Simultaneous IF + DM write: DM first, IF right after its RESP
    push_dm(1'b1, 32'h80, 32'hAA, 32'h0);
    push_if(32'h40, 32'h1234);
    expect_mem(1'b1, 32'h80, 32'hAA);
    expect_mem(1'b0, 32'h40, 32'h0);
    wait_ready(1'b1, n);
    check("dm_first_latency", 80'(n), 80'd3);
    wait_ready(1'b0, n);
    check("if_after_dm", 80'(n), 80'd3);
    wait_quiet();

    // Fairness: IF held, DM keeps requesting; IF wins the 5th arbitration
    push_if(32'h200, 32'hCAFE_0200);
    for (int i = 0; i < 5; i++)
      push_dm(1'b0, 32'h300 + 32'(i * 4), 32'h0, (32'h300 + 32'(i * 4)) ^ 32'h5A5A_0000);
    for (int i = 0; i < 4; i++) expect_mem(1'b0, 32'h300 + 32'(i * 4), 32'h0);
    expect_mem(1'b0, 32'h200, 32'h0);
    expect_mem(1'b0, 32'h310, 32'h0);
    wait_quiet();

    // Stray acks in IDLE are ignored
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      check("stray_idle_no_req", 80'({mem_req_o, stall_o}), 80'd0);
    end
    force_ack = 1'b0;
    @(posedge clk_i);
    #1;

    // Extra ack lands in RESP; next grant still proceeds normally
    ack_extra = 1'b1;
    push_dm(1'b0, 32'h44, 32'h0, 32'h4444);
    push_if(32'h40, 32'h1234);
    expect_mem(1'b0, 32'h44, 32'h0);
    expect_mem(1'b0, 32'h40, 32'h0);
    wait_quiet();
    ack_extra = 1'b0;

    // Slow memory: stall held while waiting
    ack_delay = 3;
    push_if(32'h104, 32'h5A5A_0104);
    expect_mem(1'b0, 32'h104, 32'h0);
    wait_ready(1'b0, n);
    check("if_ack_delay3", 80'(n), 80'd6);
    wait_quiet();

    // Ack in the last allowed ISSUE cycle beats the timeout
    ack_delay = 7;
    push_if(32'h40, 32'h1234);
    expect_mem(1'b0, 32'h40, 32'h0);
    wait_ready(1'b0, n);
    check("ack_at_limit_latency", 80'(n), 80'd10);
    check("ack_at_limit_err", 80'(err_o), 80'd0);
    wait_quiet();
    ack_delay = 0;

    // Timeout: no ack for 8 ISSUE cycles
    ack_en = 1'b0;
    push_if(32'h100, 32'hDEAD_BEEF);
    expect_mem(1'b0, 32'h100, 32'h0);
    wait_ready(1'b0, n);
    check("timeout_latency", 80'(n), 80'd10);
    check("timeout_err", 80'(err_o), 80'd1);
    wait_quiet();
    repeat (3) @(posedge clk_i);
    #1;
    check("err_sticky", 80'(err_o), 80'd1);

    // Reset while in ISSUE: request drops at once, no ready
    begin
      req_t r;
      r = '{we: 1'b1, addr: 32'h88, wdata: 32'h99};
      dm_q.push_back(r);
    end
    expect_mem(1'b1, 32'h88, 32'h99);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!mem_req_o && n < 20);
    check("mem_req_before_rst", 80'(mem_req_o), 80'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_mid_mem_req", 80'(mem_req_o), 80'd0);
    check("rst_mid_ready", 80'({if_ready_o, dm_ready_o}), 80'd0);
    check("rst_mid_err", 80'(err_o), 80'd0);
    dm_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i  = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      check("post_rst_idle", 80'({mem_req_o, if_ready_o, dm_ready_o}), 80'd0);
    end

    // Normal operation after reset
    push_if(32'h40, 32'h1234);
    expect_mem(1'b0, 32'h40, 32'h0);
    wait_ready(1'b0, n);
    check("post_rst_latency", 80'(n), 80'd3);
    wait_quiet();

    check("if_exp_drained",  80'(if_exp.size()),  80'd0);
    check("dm_exp_drained",  80'(dm_exp.size()),  80'd0);
    check("mem_exp_drained", 80'(mem_exp.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
